data_sram_responder: RTL

- Word-addressed, single-port, synchronous data SRAM model.
- Serves the data-side request interface that the memory stage drives (en, byte write enables, address, write data).
- Returns read data after a fixed, parameterised latency, with a valid strobe for the writeback stage.
- Counts accesses and flags out-of-range addresses, so the same block serves as the simulation and FPGA data memory of the 5-stage CPU.

---
 rtl/data_sram_if.sv | 28 ++
 rtl/data_sram_responder.sv | 90 +++++++++
 2 files changed

// File: rtl/data_sram_if.sv
// Data-side SRAM request/response bus between the memory stage and the data memory.
// The memory stage is the master; the SRAM responder is the slave.
interface data_sram_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_sram_rvalid;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata,
        input  data_sram_rvalid
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata,
        output data_sram_rvalid
    );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed single-port data SRAM with fixed-latency pipelined reads,
// access counters and a sticky out-of-range flag. READ_LAT is legal in 1..4.
module data_sram_responder #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned READ_LAT  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          resetn,
    data_sram_if.slave    bus,
    output logic          addr_err,
    output logic [31:0]   rd_count,
    output logic [31:0]   wr_count
);
    localparam int unsigned DEPTH     = 1 << ADDR_BITS;
    localparam int unsigned OFF_SHIFT = ADDR_BITS + 2;

    logic [31:0]          mem [DEPTH];
    logic [31:0]          offset_c;
    logic [ADDR_BITS-1:0] idx_c;
    logic                 in_range_c;
    logic                 is_rd_c;
    logic                 is_wr_c;
    logic [31:0]          rd_word_c;

    logic                 pipe_vld [READ_LAT];
    logic [31:0]          pipe_dat [READ_LAT];

    // Address decode relative to the window base; wraps below BASE_ADDR fall out of range.
    always_comb begin
        offset_c   = bus.data_sram_addr - BASE_ADDR;
        idx_c      = offset_c[OFF_SHIFT-1:2];
        in_range_c = (offset_c >> OFF_SHIFT) == 32'd0;
        is_rd_c    = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
        is_wr_c    = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
        rd_word_c  = in_range_c ? mem[idx_c] : 32'h0;
    end

    // Array storage is never reset; writes are suppressed on the reset edge.
    always_ff @(posedge clk) begin
        if (resetn && is_wr_c && in_range_c) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.data_sram_wen[i]) begin
                    mem[idx_c][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: data only advances with its valid so the last stage holds when idle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld[i] <= 1'b0;
                pipe_dat[i] <= 32'h0;
            end
        end else begin
            pipe_vld[0] <= is_rd_c;
            if (is_rd_c) begin
                pipe_dat[0] <= rd_word_c;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                if (pipe_vld[i-1]) begin
                    pipe_dat[i] <= pipe_dat[i-1];
                end
            end
        end
    end

    assign bus.data_sram_rvalid = pipe_vld[READ_LAT-1];
    assign bus.data_sram_rdata  = pipe_dat[READ_LAT-1];

    // Access statistics; out-of-range accesses are flagged but not counted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_err <= 1'b0;
            rd_count <= 32'h0;
            wr_count <= 32'h0;
        end else if (bus.data_sram_en) begin
            if (!in_range_c) begin
                addr_err <= 1'b1;
            end else if (is_wr_c) begin
                wr_count <= wr_count + 32'd1;
            end else begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end
endmodule
